// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single main-memory port between the I-cache refill
// path and the D-cache refill/writeback path. Round-robin arbitration picks a
// winner in IDLE, then one fixed-length line burst is sequenced, one beat per
// memory acknowledge, followed by a single DONE cycle.
module mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BURST_LEN = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              icache_req,
    input  logic [ADDR_W-1:0] icache_addr,
    output logic              icache_gnt,
    output logic [DATA_W-1:0] icache_rdata,
    output logic              icache_rvalid,
    output logic              icache_done,

    input  logic              dcache_req,
    input  logic              dcache_we,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic [DATA_W-1:0] dcache_wdata,
    output logic              dcache_gnt,
    output logic [DATA_W-1:0] dcache_rdata,
    output logic              dcache_rvalid,
    output logic              dcache_wnext,
    output logic              dcache_done,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int                BEAT_W    = $clog2(BURST_LEN);
    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN * 4 - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;

    // Burst context captured when a requester wins.
    logic [ADDR_W-1:0]   base;
    logic                we;
    logic [BEAT_W-1:0]   beat;
    // Requester identity: 0 = I-cache, 1 = D-cache.
    logic                owner_d;
    logic                last_gnt_d;

    logic                grant_i;
    logic                grant_d;
    logic [ADDR_W-1:0]   beat_addr;
    logic                last_ack;

    // Round-robin pick in IDLE: a tie goes to whoever was not served last.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (icache_req && (!dcache_req || last_gnt_d)) begin
                grant_i = 1'b1;
            end else if (dcache_req) begin
                grant_d = 1'b1;
            end
        end
    end

    assign beat_addr = base + ADDR_W'({beat, 2'b00});
    assign last_ack  = mem_ack && (beat == LAST_BEAT);

    // State register; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: grant leaves IDLE, final acked beat enters DONE, DONE is one cycle.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nxt = BUSY_I;
                end else if (grant_d) begin
                    state_nxt = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (last_ack) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Burst context: latch line base and direction on grant, count acked beats,
    // and remember the winner once its burst finishes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base       <= '0;
            we         <= 1'b0;
            beat       <= '0;
            owner_d    <= 1'b0;
            last_gnt_d <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant_i) begin
                        base    <= icache_addr & ~LINE_MASK;
                        we      <= 1'b0;
                        beat    <= '0;
                        owner_d <= 1'b0;
                    end else if (grant_d) begin
                        base    <= dcache_addr & ~LINE_MASK;
                        we      <= dcache_we;
                        beat    <= '0;
                        owner_d <= 1'b1;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack) begin
                        beat <= beat + BEAT_W'(1);
                    end
                end
                DONE: begin
                    last_gnt_d <= owner_d;
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode: everything is zero except what the current owner needs;
    // read data and write-word handshakes are passed straight through on ack.
    always_comb begin
        icache_gnt    = 1'b0;
        icache_rdata  = '0;
        icache_rvalid = 1'b0;
        icache_done   = 1'b0;
        dcache_gnt    = 1'b0;
        dcache_rdata  = '0;
        dcache_rvalid = 1'b0;
        dcache_wnext  = 1'b0;
        dcache_done   = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        unique case (state)
            BUSY_I: begin
                icache_gnt = 1'b1;
                mem_req    = 1'b1;
                mem_addr   = beat_addr;
                if (mem_ack) begin
                    icache_rvalid = 1'b1;
                    icache_rdata  = mem_rdata;
                end
            end
            BUSY_D: begin
                dcache_gnt = 1'b1;
                mem_req    = 1'b1;
                mem_we     = we;
                mem_addr   = beat_addr;
                if (we) begin
                    mem_wdata = dcache_wdata;
                end
                if (mem_ack) begin
                    if (we) begin
                        dcache_wnext = 1'b1;
                    end else begin
                        dcache_rvalid = 1'b1;
                        dcache_rdata  = mem_rdata;
                    end
                end
            end
            DONE: begin
                if (owner_d) begin
                    dcache_gnt  = 1'b1;
                    dcache_done = 1'b1;
                end else begin
                    icache_gnt  = 1'b1;
                    icache_done = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios with literal expectations, then randomized
// protocol-following requesters; a transaction-level model is checked against
// the DUT outputs every cycle.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          icache_req;
    logic [AW-1:0] icache_addr;
    logic          icache_gnt;
    logic [DW-1:0] icache_rdata;
    logic          icache_rvalid;
    logic          icache_done;
    logic          dcache_req;
    logic          dcache_we;
    logic [AW-1:0] dcache_addr;
    logic [DW-1:0] dcache_wdata;
    logic          dcache_gnt;
    logic [DW-1:0] dcache_rdata;
    logic          dcache_rvalid;
    logic          dcache_wnext;
    logic          dcache_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    int compared   = 0;
    int mismatched = 0;

    // Transaction-level model: who owns the port (0 none, 1 I, 2 D), whether the
    // burst is in its completion cycle, how many beats were acked, line base.
    int            mOwner;
    bit            mDonePhase;
    int            mBeats;
    logic [AW-1:0] mBase;
    bit            mWe;
    int            mLast;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL)) dut (
        .clk(clk), .rst(rst),
        .icache_req(icache_req), .icache_addr(icache_addr), .icache_gnt(icache_gnt),
        .icache_rdata(icache_rdata), .icache_rvalid(icache_rvalid), .icache_done(icache_done),
        .dcache_req(dcache_req), .dcache_we(dcache_we), .dcache_addr(dcache_addr),
        .dcache_wdata(dcache_wdata), .dcache_gnt(dcache_gnt), .dcache_rdata(dcache_rdata),
        .dcache_rvalid(dcache_rvalid), .dcache_wnext(dcache_wnext), .dcache_done(dcache_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    function automatic int pickWinner(input bit ir, input bit dr, input int last);
        if (ir && dr) return (last == 1) ? 2 : 1;
        if (ir) return 1;
        if (dr) return 2;
        return 0;
    endfunction

    // Model update on each edge, forgetting everything on reset.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mOwner     <= 0;
            mDonePhase <= 1'b0;
            mBeats     <= 0;
            mBase      <= '0;
            mWe        <= 1'b0;
            mLast      <= 2;
        end else if (mOwner == 0) begin
            if (pickWinner(icache_req, dcache_req, mLast) == 1) begin
                mOwner <= 1;
                mBase  <= icache_addr & ~AW'(BL * 4 - 1);
                mWe    <= 1'b0;
                mBeats <= 0;
            end else if (pickWinner(icache_req, dcache_req, mLast) == 2) begin
                mOwner <= 2;
                mBase  <= dcache_addr & ~AW'(BL * 4 - 1);
                mWe    <= dcache_we;
                mBeats <= 0;
            end
        end else if (mDonePhase) begin
            mLast      <= mOwner;
            mOwner     <= 0;
            mDonePhase <= 1'b0;
        end else if (mem_ack) begin
            mBeats <= mBeats + 1;
            if (mBeats + 1 == BL) mDonePhase <= 1'b1;
        end
    end

    task automatic checkSig(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput();
        bit busy;
        bit isI;
        bit isD;
        busy = (mOwner != 0) && !mDonePhase;
        isI  = (mOwner == 1);
        isD  = (mOwner == 2);
        checkSig("mem_req", mem_req, busy);
        checkSig("mem_we", mem_we, busy && isD && mWe);
        checkSig("mem_addr", mem_addr, busy ? (mBase + AW'(4 * mBeats)) : '0);
        checkSig("mem_wdata", mem_wdata, (busy && isD && mWe) ? dcache_wdata : '0);
        checkSig("icache_gnt", icache_gnt, isI);
        checkSig("dcache_gnt", dcache_gnt, isD);
        checkSig("icache_rvalid", icache_rvalid, busy && isI && mem_ack);
        checkSig("icache_rdata", icache_rdata, (busy && isI && mem_ack) ? mem_rdata : '0);
        checkSig("dcache_rvalid", dcache_rvalid, busy && isD && !mWe && mem_ack);
        checkSig("dcache_rdata", dcache_rdata, (busy && isD && !mWe && mem_ack) ? mem_rdata : '0);
        checkSig("dcache_wnext", dcache_wnext, busy && isD && mWe && mem_ack);
        checkSig("icache_done", icache_done, isI && mDonePhase);
        checkSig("dcache_done", dcache_done, isD && mDonePhase);
    endtask

    // Per-cycle model comparison, mid-cycle with inputs settled.
    always @(negedge clk) begin
        if (rst === 1'b1) checkOutput();
    end

    // Drive one cycle of inputs just after the edge; leave time for outputs to settle.
    task automatic applyStimulus(input bit ir, input logic [AW-1:0] ia, input bit dr,
                                 input bit dw, input logic [AW-1:0] da, input bit ack);
        @(posedge clk);
        #1;
        icache_req   = ir;
        icache_addr  = ia;
        dcache_req   = dr;
        dcache_we    = dw;
        dcache_addr  = da;
        mem_ack      = ack;
        mem_rdata    = $urandom;
        dcache_wdata = $urandom;
        #2;
    endtask

    task automatic checkAllZero(input string tag);
        checkSig({tag, " mem_req"}, mem_req, 0);
        checkSig({tag, " mem_addr"}, mem_addr, 0);
        checkSig({tag, " mem_we"}, mem_we, 0);
        checkSig({tag, " mem_wdata"}, mem_wdata, 0);
        checkSig({tag, " icache_gnt"}, icache_gnt, 0);
        checkSig({tag, " dcache_gnt"}, dcache_gnt, 0);
        checkSig({tag, " icache_rdata"}, icache_rdata, 0);
        checkSig({tag, " dcache_rdata"}, dcache_rdata, 0);
        checkSig({tag, " dcache_rvalid"}, dcache_rvalid, 0);
        checkSig({tag, " dcache_done"}, dcache_done, 0);
    endtask

    task automatic doReset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        icache_req = 0; dcache_req = 0; dcache_we = 0; mem_ack = 1;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        rst = 1'b1;
    endtask

    int pat [7]  = '{1, 0, 0, 1, 1, 0, 1};
    int offs [7] = '{0, 4, 4, 4, 8, 12, 12};

    initial begin
        #1000000;
        mismatched++;
        $display("[TB] FAIL watchdog: time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        int cnt;
        bit ir, dr, dw, iDrop, dDrop;
        logic [AW-1:0] ia, da;
        rst = 1'b0;
        icache_req = 0; icache_addr = '0; dcache_req = 0; dcache_we = 0;
        dcache_addr = '0; dcache_wdata = '0; mem_rdata = '0; mem_ack = 0;
        doReset();

        // I-cache refill, ack tied high
        applyStimulus(1, 32'h104, 0, 0, 0, 1);
        checkSig("t1 idle gnt", icache_gnt, 0);
        cnt = 0;
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1, 32'h104, 0, 0, 0, 1);
            checkSig($sformatf("t1 addr%0d", b), mem_addr, 32'h100 + 4 * b);
            checkSig($sformatf("t1 rdata%0d", b), icache_rdata, mem_rdata);
            cnt += int'(icache_rvalid);
        end
        checkSig("t1 rvalid count", cnt, 4);
        applyStimulus(1, 32'h104, 0, 0, 0, 1);
        checkSig("t1 done", icache_done, 1);
        checkSig("t1 done mem_req", mem_req, 0);
        applyStimulus(0, 32'h104, 0, 0, 0, 1);
        checkSig("t1 done cleared", icache_done, 0);

        // D-cache writeback
        applyStimulus(0, 0, 1, 1, 32'h2008, 1);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(0, 0, 1, 1, 32'h2008, 1);
            checkSig($sformatf("t2 addr%0d", b), mem_addr, 32'h2000 + 4 * b);
            checkSig($sformatf("t2 we%0d", b), mem_we, 1);
            checkSig($sformatf("t2 wnext%0d", b), dcache_wnext, 1);
            checkSig($sformatf("t2 wdata%0d", b), mem_wdata, dcache_wdata);
            checkSig($sformatf("t2 igпосле%0d", b), icache_gnt, 0);
        end
        applyStimulus(0, 0, 1, 1, 32'h2008, 1);
        checkSig("t2 done", dcache_done, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Simultaneous requests: I, then D, then I
        doReset();
        applyStimulus(1, 32'h1000, 1, 0, 32'h1100, 1);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1, 32'h1000, 1, 0, 32'h1100, 1);
            if (b == 0) begin
                checkSig("t3 first igrant", icache_gnt, 1);
                checkSig("t3 first dgrant", dcache_gnt, 0);
            end
        end
        applyStimulus(1, 32'h1000, 1, 0, 32'h1100, 1);
        applyStimulus(0, 32'h1000, 1, 0, 32'h1100, 1);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1, 32'h1000, 1, 0, 32'h1100, 1);
            if (b == 0) begin
                checkSig("t3 second dgrant", dcache_gnt, 1);
                checkSig("t3 second igrant", icache_gnt, 0);
            end
        end
        applyStimulus(1, 32'h1000, 1, 0, 32'h1100, 1);
        applyStimulus(1, 32'h1000, 0, 0, 32'h1100, 1);
        for (int b = 0; b < 4; b++) begin
            applyStimulus(1, 32'h1000, 0, 0, 32'h1100, 1);
            if (b == 0) checkSig("t3 third igrant", icache_gnt, 1);
        end
        applyStimulus(1, 32'h1000, 0, 0, 32'h1100, 1);
        applyStimulus(0, 32'h1000, 0, 0, 32'h1100, 1);

        // Stalled read burst
        applyStimulus(1, 32'h80C, 0, 0, 0, 0);
        cnt = 0;
        for (int p = 0; p < 7; p++) begin
            applyStimulus(1, 32'h80C, 0, 0, 0, pat[p] != 0);
            checkSig($sformatf("t4 addr%0d", p), mem_addr, 32'h800 + offs[p]);
            cnt += int'(icache_rvalid);
        end
        checkSig("t4 rvalid count", cnt, 4);
        applyStimulus(1, 32'h80C, 0, 0, 0, 0);
        checkSig("t4 done", icache_done, 1);
        applyStimulus(0, 32'h80C, 0, 0, 0, 0);

        // Reset mid D-cache refill (last grant was I before this)
        applyStimulus(0, 0, 1, 0, 32'h3004, 1);
        applyStimulus(0, 0, 1, 0, 32'h3004, 1);
        applyStimulus(0, 0, 1, 0, 32'h3004, 1);
        applyStimulus(0, 0, 1, 0, 32'h3004, 1);
        checkSig("t5 addr before reset", mem_addr, 32'h3008);
        rst = 1'b0;
        #1;
        checkAllZero("t5 async");
        @(posedge clk);
        #1;
        checkSig("t5 no done", dcache_done, 0);
        icache_req = 1; icache_addr = 32'h4000; dcache_req = 1; dcache_addr = 32'h5000;
        rst = 1'b1;
        applyStimulus(1, 32'h4000, 1, 0, 32'h5000, 1);
        checkSig("t5 igrant after reset", icache_gnt, 1);
        checkSig("t5 dgrant after reset", dcache_gnt, 0);

        // Late D request during an I burst
        doReset();
        applyStimulus(1, 32'h600, 0, 0, 32'h700, 1);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(k <= 5, 32'h600, k >= 2, 0, 32'h700, 1);
            checkSig($sformatf("t6 dgnt N+%0d", k), dcache_gnt, k == 7);
        end
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 1, 0, 32'h700, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);

        // Randomized traffic from protocol-following requesters
        ir = 0; dr = 0; dw = 0; ia = '0; da = '0; iDrop = 0; dDrop = 0;
        for (int c = 0; c < 3000; c++) begin
            if (iDrop) ir = 0;
            else if (!ir && ($urandom % 4 == 0)) begin
                ir = 1;
                ia = ($urandom % 8 == 0) ? (32'hFFFFFFF0 | AW'($urandom % 16)) : AW'($urandom);
            end
            if (dDrop) dr = 0;
            else if (!dr && ($urandom % 4 == 0)) begin
                dr = 1;
                dw = $urandom % 2;
                da = ($urandom % 8 == 0) ? (32'hFFFFFFF0 | AW'($urandom % 16)) : AW'($urandom);
            end
            applyStimulus(ir, ia, dr, dw, da, ($urandom % 3) != 0);
            iDrop = (mOwner == 1) && mDonePhase;
            dDrop = (mOwner == 2) && mDonePhase;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
